time_tag_gate_ctrl: RTL and testbench

Sequencer for the trigger-qualification gate in the time-tagging path.
- Once armed, opens a gate of programmable length on the next PPS edge.
- Qualifies trigger rising edges against that gate (gate AND trigger).
- Latches the PPS-relative clock count of the first qualified trigger and hands it to readout via valid/ack.
- Enforces a holdoff, then re-arms.

---
 rtl/time_tag_gate_ctrl.sv | 143 ++++++++++++++
 tb/tb_time_tag_gate_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_tag_gate_ctrl.sv
// Trigger-qualification gate sequencer for the time-tagging path.
// Arm, open a gate of win_len clocks on the next PPS edge, tag the first
// qualified trigger with the PPS-relative count, hand it to readout, then
// hold off and re-arm.
module time_tag_gate_ctrl #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 16,
  parameter int QC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pps,
  input  logic             trig_in,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [WIN_W-1:0] holdoff_len,
  input  logic             tag_ack,
  output logic             gate_out,
  output logic             trig_qual,
  output logic             tag_valid,
  output logic [CNT_W-1:0] tag_clk,
  output logic [QC_W-1:0]  qual_count,
  output logic             miss,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ARMED, OPEN, REPORT, HOLDOFF} state_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [QC_W-1:0]  QC_ONE  = QC_W'(1);

  state_t            state, state_n;
  logic              pps_d, trig_d;
  logic              pps_rise, trig_rise;
  logic [CNT_W-1:0]  pps_cnt;
  logic [WIN_W-1:0]  win_cnt, ho_cnt;
  logic              capture, expire, load_win, load_ho;

  assign pps_rise  = pps & ~pps_d;
  assign trig_rise = trig_in & ~trig_d;
  assign gate_out  = (state == OPEN);
  assign trig_qual = gate_out & trig_rise;
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode and datapath strobes; abort overrides everything
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    expire   = 1'b0;
    load_win = 1'b0;
    load_ho  = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (arm) state_n = ARMED;
        ARMED: begin
          if (pps_rise && (win_len != '0)) begin
            load_win = 1'b1;
            state_n  = OPEN;
          end
        end
        OPEN: begin
          // A trigger on the last window cycle takes priority over expiry
          if (trig_qual) begin
            capture = 1'b1;
            state_n = REPORT;
          end else if (win_cnt == WIN_ONE) begin
            expire  = 1'b1;
            state_n = IDLE;
          end
        end
        REPORT: begin
          if (tag_ack) begin
            if (holdoff_len == '0) begin
              state_n = ARMED;
            end else begin
              load_ho = 1'b1;
              state_n = HOLDOFF;
            end
          end
        end
        HOLDOFF: if (ho_cnt == WIN_ONE) state_n = ARMED;
        default: state_n = IDLE;
      endcase
    end
  end

  // Edge-detect history and free-running saturating PPS-relative counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pps_d   <= 1'b0;
      trig_d  <= 1'b0;
      pps_cnt <= '0;
    end else begin
      pps_d  <= pps;
      trig_d <= trig_in;
      if (pps_rise)             pps_cnt <= '0;
      else if (pps_cnt != '1)   pps_cnt <= pps_cnt + CNT_ONE;
    end
  end

  // Window and holdoff down-counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      ho_cnt  <= '0;
    end else begin
      if (load_win)             win_cnt <= win_len;
      else if (state == OPEN)   win_cnt <= win_cnt - WIN_ONE;
      if (load_ho)              ho_cnt  <= holdoff_len;
      else if (state == HOLDOFF) ho_cnt <= ho_cnt - WIN_ONE;
    end
  end

  // Tag capture, readout handshake, qualified count and miss pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_clk    <= '0;
      qual_count <= '0;
      tag_valid  <= 1'b0;
      miss       <= 1'b0;
    end else begin
      miss <= expire;
      if (capture) begin
        tag_clk <= pps_cnt;
        if (qual_count != '1) qual_count <= qual_count + QC_ONE;
      end
      if (abort)                                 tag_valid <= 1'b0;
      else if (capture)                          tag_valid <= 1'b1;
      else if ((state == REPORT) && tag_ack)     tag_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_time_tag_gate_ctrl.sv
// Scoreboard bench for time_tag_gate_ctrl: the stimulus pushes expected tag
// and miss events, a negedge monitor pops and compares them as they appear.
module tb_time_tag_gate_ctrl;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int QC_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pps = 1'b0, trig_in = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [WIN_W-1:0] win_len = '0, holdoff_len = '0;
  logic             tag_ack = 1'b0;
  logic             gate_out, trig_qual, tag_valid, miss, busy;
  logic [CNT_W-1:0] tag_clk;
  logic [QC_W-1:0]  qual_count;

  time_tag_gate_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .QC_W(QC_W)) dut (
    .clk(clk), .rst(rst), .pps(pps), .trig_in(trig_in), .arm(arm),
    .abort(abort), .win_len(win_len), .holdoff_len(holdoff_len),
    .tag_ack(tag_ack), .gate_out(gate_out), .trig_qual(trig_qual),
    .tag_valid(tag_valid), .tag_clk(tag_clk), .qual_count(qual_count),
    .miss(miss), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_miss;
    logic [CNT_W-1:0] tag;
    logic [QC_W-1:0]  qc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_tag(input logic [CNT_W-1:0] t, input logic [QC_W-1:0] q);
    exp_t e;
    e.is_miss = 1'b0; e.tag = t; e.qc = q;
    exp_q.push_back(e);
  endtask

  task automatic push_miss();
    exp_t e;
    e.is_miss = 1'b1; e.tag = '0; e.qc = '0;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new tag (tag_valid rising) or a miss pulse pops one entry
  logic prev_tv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_tv = 1'b0;
    end else begin
      if (tag_valid && !prev_tv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_tag: unexpected tag %0d", tag_clk);
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind_tag", {31'd0, e.is_miss}, 32'd0);
          chk("mon_tag_clk", 32'(tag_clk), 32'(e.tag));
          chk("mon_qual_count", 32'(qual_count), 32'(e.qc));
        end
      end
      if (miss) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_miss: unexpected miss pulse got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind_miss", {31'd0, e.is_miss}, 32'd1);
        end
      end
      prev_tv = tag_valid;
    end
  end

  initial begin
    int  n;
    bit  stable;

    // Reset state
    cyc(); cyc();
    chk("rst_gate", 32'(gate_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tv", 32'(tag_valid), 0);
    chk("rst_qc", 32'(qual_count), 0);
    rst = 1'b0;
    win_len = 16'd10; holdoff_len = 16'd3;
    cyc();

    // Test 1: pps at T, trigger at T+5 -> tag 4
    arm = 1'b1; cyc(); arm = 1'b0;
    chk("t1_armed_busy", 32'(busy), 1);
    pps = 1'b1;
    chk("t1_gate_T", 32'(gate_out), 0);
    cyc();
    chk("t1_gate_T1", 32'(gate_out), 1);
    cyc(); cyc(); cyc();
    cyc();
    trig_in = 1'b1;
    push_tag(8'd4, 16'd1);
    #1 chk("t1_trig_qual", 32'(trig_qual), 1);
    cyc();
    chk("t1_gate_closed", 32'(gate_out), 0);
    chk("t1_tv", 32'(tag_valid), 1);
    trig_in = 1'b0; pps = 1'b0;

    // Test 4: hold ack low 50 cycles, then holdoff of 3
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (!(tag_valid === 1'b1 && tag_clk === 8'd4)) stable = 1'b0;
    end
    chk("t4_stable", 32'(stable), 1);
    tag_ack = 1'b1; cyc(); tag_ack = 1'b0;
    chk("t4_ho_tv", 32'(tag_valid), 0);
    chk("t4_ho_busy", 32'(busy), 1);
    trig_in = 1'b1;
    #1 chk("t4_ho_trig_ignored", 32'(trig_qual), 0);
    cyc(); trig_in = 1'b0;
    cyc(); pps = 1'b1;            // last holdoff cycle: edge ignored
    cyc();
    chk("t4_ho_pps_ignored", 32'(gate_out), 0);
    chk("t4_armed_busy", 32'(busy), 1);
    pps = 1'b0;
    cyc(); pps = 1'b1;
    push_miss();
    cyc();

    // Test 2: no trigger -> exactly 10 gate cycles, then miss
    n = 0;
    while (gate_out && n < 20) begin
      n++;
      cyc();
    end
    chk("t2_gate_len", 32'(n), 10);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_tv", 32'(tag_valid), 0);
    pps = 1'b0;

    // Test 3a: trigger on last gate cycle wins over expiry
    arm = 1'b1; cyc(); arm = 1'b0;
    pps = 1'b1; cyc(); pps = 1'b0;
    repeat (9) cyc();
    chk("t3_gate_last", 32'(gate_out), 1);
    trig_in = 1'b1;
    push_tag(8'd9, 16'd2);
    cyc(); trig_in = 1'b0;
    chk("t3_tv", 32'(tag_valid), 1);
    holdoff_len = 16'd0;
    tag_ack = 1'b1; cyc(); tag_ack = 1'b0;
    chk("t3_rearm_busy", 32'(busy), 1);
    chk("t3_rearm_tv", 32'(tag_valid), 0);

    // Test 3b: trigger one cycle after the gate closes
    pps = 1'b1;
    push_miss();
    cyc(); pps = 1'b0;
    repeat (9) cyc();
    cyc();
    trig_in = 1'b1;
    #1 chk("t3b_trig_late", 32'(trig_qual), 0);
    chk("t3b_gate", 32'(gate_out), 0);
    cyc(); trig_in = 1'b0;
    chk("t3b_idle", 32'(busy), 0);

    // Test 5: abort in OPEN
    arm = 1'b1; cyc(); arm = 1'b0;
    pps = 1'b1; cyc(); pps = 1'b0;
    cyc(); cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_open_abort_busy", 32'(busy), 0);
    chk("t5_open_abort_gate", 32'(gate_out), 0);
    chk("t5_open_abort_qc", 32'(qual_count), 2);

    // Abort in REPORT
    arm = 1'b1; cyc(); arm = 1'b0;
    pps = 1'b1; cyc(); pps = 1'b0;
    trig_in = 1'b1;
    push_tag(8'd0, 16'd3);
    cyc(); trig_in = 1'b0;
    chk("t5_rep_tv", 32'(tag_valid), 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_rep_abort_tv", 32'(tag_valid), 0);
    chk("t5_rep_abort_busy", 32'(busy), 0);
    chk("t5_rep_abort_qc", 32'(qual_count), 3);
    chk("t5_rep_abort_tag", 32'(tag_clk), 0);

    // arm and abort together -> IDLE
    arm = 1'b1; abort = 1'b1; cyc(); arm = 1'b0; abort = 1'b0;
    chk("t5_arm_abort", 32'(busy), 0);

    // arm while ARMED, and win_len=0 ignores PPS
    arm = 1'b1; cyc();
    win_len = 16'd0;
    cyc(); arm = 1'b0;
    chk("t5_rearm_busy", 32'(busy), 1);
    pps = 1'b1; cyc(); pps = 1'b0;
    chk("t5_wl0_gate1", 32'(gate_out), 0);
    cyc(); pps = 1'b1; cyc(); pps = 1'b0;
    chk("t5_wl0_gate2", 32'(gate_out), 0);
    chk("t5_wl0_busy", 32'(busy), 1);
    win_len = 16'd10;
    cyc(); pps = 1'b1; cyc(); pps = 1'b0;
    chk("t5_reopen", 32'(gate_out), 1);

    // Test 6: asynchronous reset mid-window
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst_gate", 32'(gate_out), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_qc", 32'(qual_count), 0);
    chk("t6_rst_tv", 32'(tag_valid), 0);
    chk("t6_rst_tag", 32'(tag_clk), 0);
    chk("t6_rst_miss", 32'(miss), 0);
    cyc(); rst = 1'b0;

    // Saturation: long window, trigger well past 2^CNT_W-1 clocks
    win_len = 16'd300;
    arm = 1'b1; cyc(); arm = 1'b0;
    pps = 1'b1; cyc(); pps = 1'b0;
    repeat (269) cyc();
    chk("t6_sat_gate", 32'(gate_out), 1);
    trig_in = 1'b1;
    push_tag(8'd255, 16'd1);
    cyc(); trig_in = 1'b0;
    tag_ack = 1'b1; cyc(); tag_ack = 1'b0;
    repeat (3) cyc();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
